// File: rtl/axi_rd_arbiter_if.sv
// AXI read address/data channel bundle between the read arbiter (master)
// and the top-level AXI port (slave).
interface axi_rd_arbiter_if #(
   parameter int LEN_W = 4
);
   logic [3:0]       arid;
   logic [31:0]      araddr;
   logic [LEN_W-1:0] arlen;
   logic [2:0]       arsize;
   logic [1:0]       arburst;
   logic [1:0]       arlock;
   logic [3:0]       arcache;
   logic [2:0]       arprot;
   logic             arvalid;
   logic             arready;
   logic [3:0]       rid;
   logic [31:0]      rdata;
   logic             rlast;
   logic             rvalid;
   logic             rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      input  arready, rid, rdata, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      output arready, rid, rdata, rlast, rvalid
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the instruction
// and data sram-like requesters; one AR transaction in flight at a time.
module axi_rd_arbiter #(
   parameter logic [3:0] ID_INST = 4'd0,
   parameter logic [3:0] ID_DATA = 4'd1,
   parameter int         LEN_W   = 4
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              inst_req,
   input  logic [31:0]       inst_addr,
   input  logic [LEN_W-1:0]  inst_len,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic              inst_rlast,
   input  logic              data_req,
   input  logic [31:0]       data_addr,
   input  logic [2:0]        data_size,
   input  logic [LEN_W-1:0]  data_len,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic              data_rlast,
   output logic [31:0]       rdata_o,
   output logic              err,
   axi_rd_arbiter_if.master  axi
);
   typedef enum logic [1:0] {IDLE, AR, R} state_e;

   state_e           state_q, state_d;
   logic             last_data_q, last_data_d;  // 1: data holds/held the grant
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [2:0]       size_q, size_d;
   logic [3:0]       id_q, id_d;
   logic             arvalid_q, arvalid_d;
   logic             rready_q, rready_d;
   logic             err_q, err_d;
   logic [LEN_W:0]   cnt_q, cnt_d;
   logic             gnt_data, ar_hs, beat, hit;

   assign ar_hs = arvalid_q & axi.arready;
   assign beat  = rready_q & axi.rvalid;
   assign hit   = beat & (axi.rid == id_q);

   always_comb begin
      state_d     = state_q;
      last_data_d = last_data_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      id_d        = id_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      gnt_data    = 1'b0;
      case (state_q)
         IDLE: if (inst_req || data_req) begin
            gnt_data    = data_req & (~inst_req | ~last_data_q);
            last_data_d = gnt_data;
            addr_d      = gnt_data ? data_addr : inst_addr;
            len_d       = gnt_data ? data_len  : inst_len;
            size_d      = gnt_data ? data_size : 3'd2;
            id_d        = gnt_data ? ID_DATA   : ID_INST;
            arvalid_d   = 1'b1;
            state_d     = AR;
         end
         AR: if (ar_hs) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            cnt_d     = '0;
            state_d   = R;
         end
         R: begin
            // foreign-id beats are swallowed so the bus never stalls on them
            if (beat && !hit) err_d = 1'b1;
            if (hit) begin
               cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
               if (axi.rlast) begin
                  if (cnt_q != {1'b0, len_q}) err_d = 1'b1;
                  rready_d = 1'b0;
                  state_d  = IDLE;
               end else if (cnt_q >= {1'b0, len_q}) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         last_data_q <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         id_q        <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_data_q <= last_data_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         size_q      <= size_d;
         id_q        <= id_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign inst_addr_ok = ar_hs & ~last_data_q;
   assign data_addr_ok = ar_hs & last_data_q;
   assign inst_data_ok = hit & ~last_data_q;
   assign data_data_ok = hit & last_data_q;
   assign inst_rlast   = inst_data_ok & axi.rlast;
   assign data_rlast   = data_data_ok & axi.rlast;
   assign rdata_o      = axi.rdata;
   assign err          = err_q;

   assign axi.arid    = id_q;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = len_q;
   assign axi.arsize  = size_q;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: acts as the AXI slave and both
// requesters, checking grants, beats and error flag against a simple model.
module tb_axi_rd_arbiter;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic        inst_req, data_req;
   logic [31:0] inst_addr, data_addr;
   logic [3:0]  inst_len, data_len;
   logic [2:0]  data_size;
   logic        inst_addr_ok, inst_data_ok, inst_rlast;
   logic        data_addr_ok, data_data_ok, data_rlast;
   logic [31:0] rdata_o;
   logic        err;

   axi_rd_arbiter_if #(.LEN_W(4)) axi ();

   axi_rd_arbiter #(.ID_INST(4'd0), .ID_DATA(4'd1), .LEN_W(4)) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rlast(inst_rlast),
      .data_req(data_req), .data_addr(data_addr), .data_size(data_size), .data_len(data_len),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rlast(data_rlast),
      .rdata_o(rdata_o), .err(err), .axi(axi)
   );

   always #5 aclk = ~aclk;

   int vectors = 0;
   int miscompares = 0;

   // observations collected by serve()
   int          ob_lat, ob_iaok, ob_daok, ob_idok, ob_ddok, ob_ilast, ob_dlast, ob_lastidx, ob_nrdy;
   bit          ob_to, ob_stable;
   logic [3:0]  ob_arid, ob_arlen;
   logic [31:0] ob_araddr;
   logic [2:0]  ob_arsize;
   logic [31:0] q_rd[$];
   logic [31:0] exp_q[$];
   logic [31:0] beat_data[16];
   bit          m_last;  // model: 1 if data was granted most recently

   // reference: beats a requester should see (foreign-id beat removed)
   function automatic void build_exp(input int nbeats, input int bad_at);
      exp_q.delete();
      for (int i = 0; i < nbeats; i++) if (i != bad_at) exp_q.push_back(beat_data[i]);
   endfunction

   // reference: error if any foreign beat, rlast at wrong position, or overrun
   function automatic bit exp_err(input int len, input int nbeats, input int last_at, input int bad_at);
      int good = 0;
      for (int i = 0; i < nbeats; i++) begin
         if (i == bad_at) return 1'b1;
         if (i == last_at) return (good != len);
         if (good >= len) return 1'b1;
         good++;
      end
      return 1'b0;
   endfunction

   function automatic int data_diff();
      int d = (q_rd.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size(); i++) if (i < q_rd.size() && q_rd[i] !== exp_q[i]) d++;
      return d;
   endfunction

   task automatic do_reset();
      aresetn = 1'b0;
      inst_req = 0; data_req = 0; inst_addr = 0; data_addr = 0;
      inst_len = 0; data_len = 0; data_size = 0;
      axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rlast = 0;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      m_last = 1'b0;
   endtask

   // AXI slave: waits for arvalid, stalls arready, returns beats; records only
   task automatic serve(input int stall, input int nbeats, input int last_at,
                        input int bad_at, input bit gaps, input bit drop_early);
      int lat = 0;
      ob_iaok = 0; ob_daok = 0; ob_idok = 0; ob_ddok = 0; ob_ilast = 0; ob_dlast = 0;
      ob_lastidx = -1; ob_nrdy = 0; ob_to = 0; ob_stable = 1; q_rd.delete();
      while (1) begin
         @(negedge aclk);
         if (axi.arvalid || lat > 20) break;
         lat++;
         @(posedge aclk); #1;
      end
      if (!axi.arvalid) ob_to = 1;
      ob_lat = lat; ob_arid = axi.arid; ob_araddr = axi.araddr;
      ob_arlen = axi.arlen; ob_arsize = axi.arsize;
      if (drop_early) begin inst_req = 0; data_req = 0; end
      for (int s = 0; s < stall; s++) begin
         if (!axi.arvalid || axi.araddr !== ob_araddr || axi.arid !== ob_arid ||
             axi.arlen !== ob_arlen || axi.arsize !== ob_arsize) ob_stable = 0;
         ob_iaok += inst_addr_ok; ob_daok += data_addr_ok;
         @(posedge aclk); #1;
         @(negedge aclk);
      end
      axi.arready = 1; #1;
      if (!axi.arvalid || axi.araddr !== ob_araddr || axi.arid !== ob_arid) ob_stable = 0;
      ob_iaok += inst_addr_ok; ob_daok += data_addr_ok;
      @(posedge aclk); #1;
      axi.arready = 0;
      if (ob_iaok != 0) inst_req = 0;
      if (ob_daok != 0) data_req = 0;
      for (int b = 0; b < nbeats; b++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
         axi.rvalid = 1; axi.rid = (b == bad_at) ? 4'd5 : ob_arid;
         axi.rdata = beat_data[b]; axi.rlast = (b == last_at);
         @(negedge aclk);
         if (!axi.rready) ob_nrdy++;
         if (inst_data_ok) begin
            ob_idok++; q_rd.push_back(rdata_o);
            if (inst_rlast) begin ob_ilast++; ob_lastidx = b; end
         end
         if (data_data_ok) begin
            ob_ddok++; q_rd.push_back(rdata_o);
            if (data_rlast) begin ob_dlast++; ob_lastidx = b; end
         end
         @(posedge aclk); #1;
         axi.rvalid = 0; axi.rlast = 0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge aclk);
      vectors++;
      if ({axi.arvalid, axi.rready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err} !== 7'd0) begin
         miscompares++; $display("FAIL reset_ctrl: got %b exp 0", {axi.arvalid, axi.rready, err});
      end
      vectors++;
      if ({axi.arid, axi.araddr, axi.arlen, axi.arsize} !== 43'd0) begin
         miscompares++; $display("FAIL reset_fields: got %h exp 0", {axi.arid, axi.araddr, axi.arlen, axi.arsize});
      end
      vectors++;
      if ({axi.arburst, axi.arlock, axi.arcache, axi.arprot} !== {2'b01, 2'b00, 4'd0, 3'd0}) begin
         miscompares++; $display("FAIL ar_consts: got %h exp %h", {axi.arburst, axi.arlock, axi.arcache, axi.arprot}, {2'b01, 9'd0});
      end
      @(posedge aclk); #1;
   endtask

   task automatic test_single_inst();
      inst_addr = 32'hBFC0_0000; inst_len = 0; inst_req = 1;
      beat_data[0] = 32'h3C08_0001;
      serve(0, 1, 0, -1, 0, 0);
      build_exp(1, -1);
      vectors++;
      if (ob_to || ob_lat != 1) begin miscompares++; $display("FAIL single_latency: got %0d exp 1", ob_lat); end
      vectors++;
      if ({ob_arid, ob_araddr, ob_arlen, ob_arsize} !== {4'd0, 32'hBFC0_0000, 4'd0, 3'd2}) begin
         miscompares++; $display("FAIL single_ar: got %h exp %h", {ob_arid, ob_araddr, ob_arlen, ob_arsize}, {4'd0, 32'hBFC0_0000, 4'd0, 3'd2});
      end
      vectors++;
      if (ob_iaok != 1 || ob_daok != 0) begin miscompares++; $display("FAIL single_addr_ok: got %0d/%0d exp 1/0", ob_iaok, ob_daok); end
      vectors++;
      if (ob_idok != 1 || ob_ddok != 0 || ob_ilast != 1) begin
         miscompares++; $display("FAIL single_data_ok: got %0d/%0d last %0d exp 1/0 last 1", ob_idok, ob_ddok, ob_ilast);
      end
      vectors++;
      if (data_diff() != 0) begin miscompares++; $display("FAIL single_rdata: got %h exp 3c080001", (q_rd.size() > 0) ? q_rd[0] : 32'hx); end
      @(negedge aclk);
      vectors++;
      if ({axi.arvalid, axi.rready, err} !== 3'b000) begin miscompares++; $display("FAIL single_idle: got %b exp 000", {axi.arvalid, axi.rready, err}); end
      @(posedge aclk); #1;
      m_last = 0;
   endtask

   task automatic test_drop();
      inst_addr = $urandom; inst_len = 1; inst_req = 1;
      beat_data[0] = $urandom; beat_data[1] = $urandom;
      serve(2, 2, 1, -1, 1, 1);
      build_exp(2, -1);
      vectors++;
      if (ob_iaok != 1 || ob_idok != 2 || ob_ilast != 1) begin
         miscompares++; $display("FAIL drop_completes: got aok %0d dok %0d exp 1 2", ob_iaok, ob_idok);
      end
      vectors++;
      if (data_diff() != 0 || err !== 1'b0) begin miscompares++; $display("FAIL drop_data: got diff %0d err %b exp 0 0", data_diff(), err); end
      m_last = 0;
   endtask

   task automatic test_contention();
      do_reset();
      inst_addr = $urandom; inst_len = 4'($urandom_range(0, 3)); inst_req = 1;
      data_addr = $urandom; data_len = 4'($urandom_range(0, 3)); data_size = 3'($urandom_range(0, 2)); data_req = 1;
      for (int k = 0; k < 4; k++) begin
         bit          exp_d = !m_last;
         logic [31:0] ea = exp_d ? data_addr : inst_addr;
         logic [3:0]  el = exp_d ? data_len : inst_len;
         logic [2:0]  es = exp_d ? data_size : 3'd2;
         for (int i = 0; i <= int'(el); i++) beat_data[i] = $urandom;
         serve($urandom_range(0, 2), el + 1, el, -1, 1, 0);
         build_exp(el + 1, -1);
         vectors++;
         if ({ob_arid, ob_araddr, ob_arlen, ob_arsize} !== {exp_d ? 4'd1 : 4'd0, ea, el, es}) begin
            miscompares++; $display("FAIL contend_ar[%0d]: got %h exp %h", k, {ob_arid, ob_araddr, ob_arlen, ob_arsize}, {exp_d ? 4'd1 : 4'd0, ea, el, es});
         end
         vectors++;
         if (ob_daok != int'(exp_d) || ob_iaok != int'(!exp_d)) begin
            miscompares++; $display("FAIL contend_addr_ok[%0d]: got i%0d d%0d exp d%0d", k, ob_iaok, ob_daok, exp_d);
         end
         vectors++;
         if ((exp_d ? ob_ddok : ob_idok) != int'(el) + 1 || (exp_d ? ob_idok : ob_ddok) != 0) begin
            miscompares++; $display("FAIL contend_data_ok[%0d]: got i%0d d%0d exp %0d beats", k, ob_idok, ob_ddok, el + 1);
         end
         vectors++;
         if (data_diff() != 0 || err !== 1'b0) begin miscompares++; $display("FAIL contend_data[%0d]: got diff %0d err %b exp 0 0", k, data_diff(), err); end
         m_last = exp_d;
         if (exp_d) begin
            data_addr = $urandom; data_len = 4'($urandom_range(0, 3)); data_size = 3'($urandom_range(0, 2)); data_req = 1;
         end else begin
            inst_addr = $urandom; inst_len = 4'($urandom_range(0, 3)); inst_req = 1;
         end
      end
      inst_req = 0; data_req = 0;
      @(posedge aclk); #1;
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         int          r = $urandom_range(1, 3);
         bit          exp_d;
         logic [31:0] ea;
         logic [3:0]  el;
         logic [2:0]  es;
         inst_addr = $urandom; inst_len = 4'($urandom_range(0, 7));
         data_addr = $urandom; data_len = 4'($urandom_range(0, 7)); data_size = 3'($urandom_range(0, 3));
         inst_req = r[0]; data_req = r[1];
         exp_d = (r == 3) ? !m_last : (r == 2);
         ea = exp_d ? data_addr : inst_addr;
         el = exp_d ? data_len : inst_len;
         es = exp_d ? data_size : 3'd2;
         for (int i = 0; i <= int'(el); i++) beat_data[i] = $urandom;
         serve($urandom_range(0, 3), el + 1, el, -1, 1, 0);
         inst_req = 0; data_req = 0;
         build_exp(el + 1, -1);
         vectors++;
         if (ob_to || ob_lat != 1 || {ob_arid, ob_araddr, ob_arlen, ob_arsize} !== {exp_d ? 4'd1 : 4'd0, ea, el, es}) begin
            miscompares++; $display("FAIL rand_ar[%0d]: got lat %0d %h exp lat 1 %h", k, ob_lat, {ob_arid, ob_araddr, ob_arlen, ob_arsize}, {exp_d ? 4'd1 : 4'd0, ea, el, es});
         end
         vectors++;
         if ((exp_d ? ob_ddok : ob_idok) != int'(el) + 1 || (exp_d ? ob_dlast : ob_ilast) != 1 || ob_lastidx != int'(el)) begin
            miscompares++; $display("FAIL rand_beats[%0d]: got i%0d d%0d last@%0d exp %0d last@%0d", k, ob_idok, ob_ddok, ob_lastidx, el + 1, el);
         end
         vectors++;
         if (data_diff() != 0 || ob_nrdy != 0 || err !== 1'b0) begin
            miscompares++; $display("FAIL rand_data[%0d]: got diff %0d nrdy %0d err %b exp 0 0 0", k, data_diff(), ob_nrdy, err);
         end
         m_last = exp_d;
      end
   endtask

   task automatic test_burst_stalls();
      data_addr = $urandom; data_len = 7; data_size = 2; data_req = 1;
      for (int i = 0; i < 8; i++) beat_data[i] = $urandom;
      serve(3, 8, 7, -1, 1, 0);
      build_exp(8, -1);
      vectors++;
      if (!ob_stable || ob_lat != 1 || ob_daok != 1) begin
         miscompares++; $display("FAIL burst_ar_hold: got stable %0d lat %0d aok %0d exp 1 1 1", ob_stable, ob_lat, ob_daok);
      end
      vectors++;
      if (ob_ddok != 8 || ob_dlast != 1 || ob_lastidx != 7 || ob_idok != 0) begin
         miscompares++; $display("FAIL burst_beats: got %0d last %0d@%0d exp 8 1@7", ob_ddok, ob_dlast, ob_lastidx);
      end
      vectors++;
      if (data_diff() != 0 || err !== exp_err(7, 8, 7, -1)) begin miscompares++; $display("FAIL burst_data: got diff %0d err %b exp 0 0", data_diff(), err); end
      m_last = 1;
   endtask

   task automatic test_bad_rid();
      data_addr = $urandom; data_len = 7; data_size = 2; data_req = 1;
      for (int i = 0; i < 9; i++) beat_data[i] = $urandom;
      serve(0, 9, 8, 3, 1, 0);
      build_exp(9, 3);
      vectors++;
      if (ob_ddok != 8 || ob_dlast != 1) begin miscompares++; $display("FAIL badrid_beats: got %0d last %0d exp 8 1", ob_ddok, ob_dlast); end
      vectors++;
      if (data_diff() != 0 || err !== exp_err(7, 9, 8, 3)) begin miscompares++; $display("FAIL badrid_err: got diff %0d err %b exp 0 1", data_diff(), err); end
      m_last = 1;
   endtask

   task automatic test_early_last();
      do_reset();
      data_addr = $urandom; data_len = 7; data_size = 2; data_req = 1;
      for (int i = 0; i < 3; i++) beat_data[i] = $urandom;
      serve(0, 3, 2, -1, 0, 0);
      build_exp(3, -1);
      vectors++;
      if (ob_ddok != 3 || ob_dlast != 1 || data_diff() != 0) begin
         miscompares++; $display("FAIL early_beats: got %0d last %0d diff %0d exp 3 1 0", ob_ddok, ob_dlast, data_diff());
      end
      @(negedge aclk);
      vectors++;
      if ({axi.arvalid, axi.rready, err} !== {2'b00, exp_err(7, 3, 2, -1)}) begin
         miscompares++; $display("FAIL early_idle_err: got %b exp 001", {axi.arvalid, axi.rready, err});
      end
      @(posedge aclk); #1;
      m_last = 1;
   endtask

   task automatic test_reset_mid();
      data_addr = $urandom; data_len = 7; data_size = 2; data_req = 1;
      for (int i = 0; i < 3; i++) beat_data[i] = $urandom;
      serve(0, 3, -1, 1, 0, 0);
      @(negedge aclk);
      vectors++;
      if ({axi.rready, err} !== {1'b1, exp_err(7, 3, -1, 1)} || ob_ddok != 2) begin
         miscompares++; $display("FAIL midburst_pre: got rready %b err %b dok %0d exp 1 1 2", axi.rready, err, ob_ddok);
      end
      @(posedge aclk); #1 aresetn = 1'b0;
      @(posedge aclk); #1 aresetn = 1'b1;
      @(negedge aclk);
      vectors++;
      if ({axi.arvalid, axi.rready, err} !== 3'b000) begin miscompares++; $display("FAIL midburst_ctrl: got %b exp 000", {axi.arvalid, axi.rready, err}); end
      vectors++;
      if ({axi.arid, axi.araddr, axi.arlen, axi.arsize} !== 43'd0) begin
         miscompares++; $display("FAIL midburst_fields: got %h exp 0", {axi.arid, axi.araddr, axi.arlen, axi.arsize});
      end
      axi.rvalid = 1; axi.rid = 4'd1; axi.rlast = 1; axi.rdata = $urandom; #1;
      vectors++;
      if ({data_data_ok, inst_data_ok, axi.rready} !== 3'b000) begin
         miscompares++; $display("FAIL midburst_late_beat: got %b exp 000", {data_data_ok, inst_data_ok, axi.rready});
      end
      @(posedge aclk); #1;
      axi.rvalid = 0; axi.rlast = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_inst();
      test_drop();
      test_contention();
      test_random();
      test_burst_stalls();
      test_bad_rid();
      test_early_last();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Sequences the core's shared AXI read channel between two sram-like requesters: instruction fetch/refill and data load/refill.
- Grants one requester at a time and issues one AR transaction, single or burst.
- Steers R beats back to the granted requester, then releases the channel.
- Sits between the core's inst/data sram-like ports and the top-level AXI AR/R ports; gates the core's `*_addr_ok`.

Parameters:
- ID_INST, 4'd0, arid used for instruction transactions
- ID_DATA, 4'd1, arid used for data transactions
- LEN_W, 4, width of burst-length fields (beats-1, AXI arlen encoding)

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- inst_req  in  1  instruction read request; held until inst_addr_ok
- inst_addr  in  32  instruction read address
- inst_len  in  LEN_W  beats-1 for instruction transaction
- inst_addr_ok  out  1  request accepted (AR handshake done)
- inst_data_ok  out  1  one beat valid for instruction requester
- inst_rlast  out  1  final beat marker, qualified by inst_data_ok
- data_req  in  1  data read request; held until data_addr_ok
- data_addr  in  32  data read address
- data_size  in  3  arsize for data transaction
- data_len  in  LEN_W  beats-1 for data transaction
- data_addr_ok  out  1  request accepted
- data_data_ok  out  1  one beat valid for data requester
- data_rlast  out  1  final beat marker, qualified by data_data_ok
- rdata_o  out  32  beat data, shared by both requesters
- arid/araddr/arlen/arsize  out  4/32/4/3  AXI AR fields
- arburst/arlock/arcache/arprot  out  2/2/4/3  constants: 2'b01, 0, 0, 0
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- rid  in  4  AXI R id
- rdata  in  32  AXI R data
- rlast  in  1  AXI R last
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- err  out  1  sticky protocol error flag

Behaviour:
- States: IDLE, AR, R. Reset value is IDLE.
- Reset values: arvalid=0, rready=0, all *_ok=0, err=0, last_grant=INST, latched addr/len/size/id=0.
- Reset mid-transaction forces IDLE immediately. Outstanding beats arriving after reset are not acknowledged (rready=0).
- IDLE:
  - Sample inst_req/data_req each cycle.
  - One requester: grant it.
  - Both requesting: grant the one NOT equal to last_grant (round-robin). First contention after reset therefore goes to data.
  - On grant: latch addr, len, and size (inst: 3'd2; data: data_size); set arid to ID_INST/ID_DATA; update last_grant; go to AR.
  - arvalid rises the cycle after the request is sampled (1-cycle latency).
- AR:
  - arvalid=1 with latched fields stable.
  - On arvalid&&arready: pulse the granted `*_addr_ok` combinationally in that same cycle; go to R; clear the beat counter.
  - The ungranted requester's addr_ok stays 0.
- R:
  - rready=1.
  - Beat accepted when rvalid&&rready.
  - If rid==latched id: pulse the granted `*_data_ok`; drive rdata_o=rdata and `*_rlast`=rlast, combinationally in the same cycle; increment the beat counter.
  - If rid≠latched id: beat consumed and dropped, no data_ok, err<=1.
  - On accepted matching beat with rlast=1: go to IDLE.
    - If the beat count ≠ latched len at that beat, set err<=1 but still go to IDLE.
  - Beats beyond len without rlast: delivered, err<=1, stay in R until rlast.
- Back-to-back transactions have a minimum of one IDLE cycle between the last R beat and the next arvalid.
- A request dropped before addr_ok after grant is ignored: the latched transaction completes, and its beats are still delivered via data_ok.
- rdata_o is don't-care when no data_ok is asserted; drive rdata unconditionally.
- err is cleared only by reset.

Test Plan:
- **Single inst read:** inst_req=1, inst_addr=0xBFC00000, inst_len=0, arready=1 → arvalid at N+1, araddr=0xBFC00000, arid=0, arlen=0, arsize=2, inst_addr_ok pulse; one beat rdata=0x3C080001, rlast=1 → inst_data_ok+inst_rlast for one cycle, back in IDLE.
- **Simultaneous requests after reset:** inst and data both request → data granted first (arid=1); after completion the still-held inst_req is granted next (arid=0). Repeat twice to confirm alternation.
- **Data burst with stalls:** data_len=7, data_size=2, arready low 3 cycles → arvalid held with stable fields; 8 beats with rvalid gaps → exactly 8 data_data_ok pulses, data_rlast only on beat 8, err=0.
- **Protocol errors:**
  - Wrong rid=4'd5 beat mid-burst → dropped, no data_ok, err=1.
  - rlast on beat 3 of len=7 → IDLE, err=1.
- **Reset mid-burst:** aresetn=0 for one cycle during R → next cycle IDLE, rready=0, all outputs at reset values, err=0.
